// File: rtl/gcd_pkg.sv
// Shared types for the GCD job issuer: FSM state encoding, default width and job record.
package gcd_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // Job record at the default width; wider builds carry the same {a, b} layout flattened.
  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] a;
    logic [DATA_W_DEFAULT-1:0] b;
  } job_t;

  function automatic logic is_bypass(input logic a_zero, input logic b_zero);
    return a_zero | b_zero;
  endfunction

endpackage

// File: rtl/gcd_job_fifo.sv
// Synchronous job FIFO with show-ahead head; pointers carry a wrap bit above the index.
module gcd_job_fifo
  import gcd_pkg::*;
#(
  parameter int WIDTH = 2 * DATA_W_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers hide stale contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gcd_job_issuer.sv
// Queues GCD jobs, issues them one at a time to an external engine and delivers results in order.
// Optional watchdog on the engine wait is enabled by defining GCD_ISSUER_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a job at the FIFO head
// ISSUE   | one-cycle gcd_start with head operands
// WAIT    | engine busy; waiting for gcd_done (or watchdog)
// DELIVER | result held on out_* until out_ready
module gcd_job_issuer
  import gcd_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              gcd_start,
  output logic [DATA_W-1:0] gcd_a,
  output logic [DATA_W-1:0] gcd_b,
  input  logic              gcd_done,
  input  logic [DATA_W-1:0] gcd_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_gcd,
  output logic              busy,
  output logic              err_timeout
);

  state_t              state;
  state_t              state_nxt;
  logic [2*DATA_W-1:0] fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [DATA_W-1:0]   head_a;
  logic [DATA_W-1:0]   head_b;
  logic                out_load;
  logic [DATA_W-1:0]   out_gcd_nxt;
  logic                engine_owned;

  gcd_job_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata ({in_a, in_b}),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_a = fifo_head[2*DATA_W-1:DATA_W];
  assign head_b = fifo_head[DATA_W-1:0];

  assign in_ready  = !fifo_full;
  assign busy      = !fifo_empty || (state != IDLE);
  assign out_valid = (state == DELIVER);
  assign gcd_start = (state == ISSUE);

  // The head is only popped once the engine finishes, so it doubles as the operand hold register.
  assign engine_owned = (state == ISSUE) || (state == WAIT);
  assign gcd_a        = engine_owned ? head_a : '0;
  assign gcd_b        = engine_owned ? head_b : '0;

`ifdef GCD_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          err_q;

  assign tmo_hit     = (state == WAIT) && !gcd_done && (tmo_cnt == '0);
  assign err_timeout = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= TW'(TIMEOUT - 1);
      end else if ((state == WAIT) && (tmo_cnt != '0)) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    out_load    = 1'b0;
    out_gcd_nxt = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          if (is_bypass(head_a == '0, head_b == '0)) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so an OR of the operands is exact.
            state_nxt   = DELIVER;
            fifo_pop    = 1'b1;
            out_load    = 1'b1;
            out_gcd_nxt = head_a | head_b;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (gcd_done) begin
          state_nxt   = DELIVER;
          fifo_pop    = 1'b1;
          out_load    = 1'b1;
          out_gcd_nxt = gcd_result;
        end
`ifdef GCD_ISSUER_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt   = DELIVER;
          fifo_pop    = 1'b1;
          out_load    = 1'b1;
          out_gcd_nxt = '0;
        end
`endif
      end
      DELIVER: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a   <= '0;
      out_b   <= '0;
      out_gcd <= '0;
    end else if (out_load) begin
      out_a   <= head_a;
      out_b   <= head_b;
      out_gcd <= out_gcd_nxt;
    end
  end

endmodule

// File: tb/tb_gcd_job_issuer.sv
// Self-checking bench for gcd_job_issuer with a behavioural 5-cycle GCD engine and a result scoreboard.
module tb_gcd_job_issuer;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              gcd_start;
  logic [DATA_W-1:0] gcd_a;
  logic [DATA_W-1:0] gcd_b;
  logic              gcd_done;
  logic [DATA_W-1:0] gcd_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_gcd;
  logic              busy;
  logic              err_timeout;

  gcd_job_issuer #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .gcd_start   (gcd_start),
    .gcd_a       (gcd_a),
    .gcd_b       (gcd_b),
    .gcd_done    (gcd_done),
    .gcd_result  (gcd_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_gcd     (out_gcd),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] g;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   starts   = 0;
  int   double_starts = 0;
  bit   eng_stall = 1'b0;
  bit   eng_flush = 1'b0;
  bit   saw_done  = 1'b0;

  function automatic logic [DATA_W-1:0] ref_gcd(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Engine model: samples gcd_start on the falling edge, answers 5 cycles later unless stalled.
  initial begin
    bit                pend;
    int                cnt;
    logic [DATA_W-1:0] res;
    pend = 1'b0;
    cnt = 0;
    res = '0;
    gcd_done = 1'b0;
    gcd_result = '0;
    forever begin
      @(negedge clk);
      gcd_done = 1'b0;
      if (eng_flush) pend = 1'b0;
      if (pend && !eng_stall) begin
        if (cnt == 1) begin
          gcd_done = 1'b1;
          gcd_result = res;
          pend = 1'b0;
          saw_done = 1'b1;
        end else begin
          cnt--;
        end
      end
      if (gcd_start === 1'b1) begin
        if (pend) double_starts++;
        starts++;
        pend = 1'b1;
        cnt = 5;
        res = ref_gcd(gcd_a, gcd_b);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic push_job(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    acc = in_ready;
    if (acc) begin
      e.a = a;
      e.b = b;
      e.g = ref_gcd(a, b);
      sb.push_back(e);
    end
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit found);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gcd_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [6*DATA_W+3:0] obs;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #1;
    obs = {gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd, busy, err_timeout, in_ready};
    n_checks++;
    if (obs !== {1'b0, {6{{DATA_W{1'b0}}}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected all zero with in_ready=1", obs);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, out_valid} !== 3'b010) begin
      n_fail++;
      $display("FAIL reset_release: busy/in_ready/out_valid=%b expected 010", {busy, in_ready, out_valid});
    end
  endtask

  task automatic test_single();
    bit acc, f;
    int s0;
    exp_t e;
    s0 = starts;
    push_job(16'd56, 16'd14, acc);
    stop_in();
    wait_out(f);
    n_checks++;
    if (!f) begin
      n_fail++;
      $display("FAIL single_out: out_valid not seen, expected result 14");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (out_gcd !== e.g) begin
        n_fail++;
        $display("FAIL single_gcd: got %0d expected %0d", out_gcd, e.g);
      end
      n_checks++;
      if ({out_a, out_b} !== {e.a, e.b}) begin
        n_fail++;
        $display("FAIL single_echo: got (%0d,%0d) expected (%0d,%0d)", out_a, out_b, e.a, e.b);
      end
      accept();
    end
    n_checks++;
    if (starts - s0 != 1) begin
      n_fail++;
      $display("FAIL single_starts: got %0d starts expected 1", starts - s0);
    end
  endtask

  task automatic test_back_to_back();
    bit acc, f;
    int s0;
    exp_t e;
    s0 = starts;
    push_job(16'd90, 16'd45, acc);
    push_job(16'd49, 16'd57, acc);
    stop_in();
    for (int k = 0; k < 2; k++) begin
      wait_out(f);
      n_checks++;
      if (!f || sb.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_out%0d: out_valid not seen", k);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({out_a, out_b, out_gcd} !== {e.a, e.b, e.g}) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got (%0d,%0d)->%0d expected (%0d,%0d)->%0d",
                   k, out_a, out_b, out_gcd, e.a, e.b, e.g);
        end
        accept();
      end
    end
    n_checks++;
    if (double_starts != 0 || starts - s0 != 2) begin
      n_fail++;
      $display("FAIL b2b_starts: got %0d starts, %0d overlapping, expected 2 and 0",
               starts - s0, double_starts);
    end
  endtask

  task automatic test_bypass();
    bit acc, f;
    int s0;
    exp_t e;
    s0 = starts;
    push_job(16'd0, 16'd12, acc);
    push_job(16'd0, 16'd0, acc);
    stop_in();
    for (int k = 0; k < 2; k++) begin
      wait_out(f);
      n_checks++;
      if (!f || sb.size() == 0) begin
        n_fail++;
        $display("FAIL bypass_out%0d: out_valid not seen", k);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({out_a, out_b, out_gcd} !== {e.a, e.b, e.g}) begin
          n_fail++;
          $display("FAIL bypass_result%0d: got (%0d,%0d)->%0d expected (%0d,%0d)->%0d",
                   k, out_a, out_b, out_gcd, e.a, e.b, e.g);
        end
        accept();
      end
    end
    n_checks++;
    if (starts != s0) begin
      n_fail++;
      $display("FAIL bypass_starts: got %0d starts expected 0", starts - s0);
    end
  endtask

  task automatic test_full();
    bit acc [5];
    bit f;
    exp_t e;
    logic [DATA_W-1:0] ja [5] = '{16'd12, 16'd100, 16'd0, 16'd17, 16'd8};
    logic [DATA_W-1:0] jb [5] = '{16'd18, 16'd75, 16'd7, 16'd13, 16'd4};
    eng_stall = 1'b1;
    for (int k = 0; k < 5; k++) push_job(ja[k], jb[k], acc[k]);
    stop_in();
    n_checks++;
    if ({acc[0], acc[1], acc[2], acc[3], acc[4]} !== 5'b11110) begin
      n_fail++;
      $display("FAIL full_accept: accepted pattern %b expected 11110",
               {acc[0], acc[1], acc[2], acc[3], acc[4]});
    end
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_in_ready: got %b expected 0", in_ready);
    end
    eng_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_out(f);
      n_checks++;
      if (!f || sb.size() == 0) begin
        n_fail++;
        $display("FAIL full_drain%0d: out_valid not seen", k);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if ({out_a, out_b, out_gcd} !== {e.a, e.b, e.g}) begin
          n_fail++;
          $display("FAIL full_result%0d: got (%0d,%0d)->%0d expected (%0d,%0d)->%0d",
                   k, out_a, out_b, out_gcd, e.a, e.b, e.g);
        end
        accept();
      end
    end
    n_checks++;
    if ({busy, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL full_idle: busy/in_ready=%b expected 01", {busy, in_ready});
    end
  endtask

  task automatic test_reset_in_wait();
    bit acc, f, bad;
    exp_t e;
    logic [6*DATA_W+3:0] obs;
    saw_done = 1'b0;
    push_job(16'd81, 16'd27, acc);
    stop_in();
    wait_start(f);
    n_checks++;
    if (!f) begin
      n_fail++;
      $display("FAIL rst_wait_start: gcd_start not seen");
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gcd_start, gcd_a, gcd_b, out_valid, out_a, out_b, out_gcd, busy, err_timeout, in_ready};
    n_checks++;
    if (obs !== {1'b0, {6{{DATA_W{1'b0}}}}, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_wait_outputs: got %h expected all zero with in_ready=1", obs);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || !saw_done) begin
      n_fail++;
      $display("FAIL rst_late_done: late done seen=%b, output activity=%b expected 1 and 0", saw_done, bad);
    end
    push_job(16'd32, 16'd48, acc);
    stop_in();
    wait_out(f);
    n_checks++;
    if (!f || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rst_next_out: out_valid not seen");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (out_gcd !== e.g) begin
        n_fail++;
        $display("FAIL rst_next_gcd: got %0d expected %0d", out_gcd, e.g);
      end
      accept();
    end
  endtask

`ifdef GCD_ISSUER_TIMEOUT_EN
  task automatic test_timeout();
    bit acc, f;
    int first_k;
    exp_t e;
    eng_stall = 1'b1;
    push_job(16'd9, 16'd6, acc);
    if (acc) sb[sb.size()-1].g = '0;
    stop_in();
    wait_start(f);
    first_k = -1;
    for (int k = 1; k <= 3 * TIMEOUT; k++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin
        first_k = k;
        break;
      end
    end
    n_checks++;
    if (first_k != TIMEOUT + 1) begin
      n_fail++;
      $display("FAIL tmo_cycle: err_timeout at %0d cycles after start expected %0d", first_k, TIMEOUT + 1);
    end
    n_checks++;
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      n_fail++;
      $display("FAIL tmo_deliver: out_valid=%b expected 1", out_valid);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({out_a, out_b, out_gcd} !== {e.a, e.b, e.g}) begin
        n_fail++;
        $display("FAIL tmo_result: got (%0d,%0d)->%0d expected (%0d,%0d)->%0d",
                 out_a, out_b, out_gcd, e.a, e.b, e.g);
      end
      accept();
    end
    eng_flush = 1'b1;
    @(negedge clk);
    eng_flush = 1'b0;
    eng_stall = 1'b0;
    push_job(16'd32, 16'd48, acc);
    stop_in();
    wait_out(f);
    n_checks++;
    if (!f || sb.size() == 0) begin
      n_fail++;
      $display("FAIL tmo_next_out: out_valid not seen");
    end else begin
      e = sb.pop_front();
      n_checks++;
      if ({out_gcd, err_timeout} !== {e.g, 1'b1}) begin
        n_fail++;
        $display("FAIL tmo_next: got gcd %0d err %b expected gcd %0d err 1", out_gcd, err_timeout, e.g);
      end
      accept();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bypass();
    test_full();
    test_reset_in_wait();
`ifdef GCD_ISSUER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_job_issuer.md
GCD_JOB_ISSUER -- requirements
Module: gcd_job_issuer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, operand/result width; DEPTH, default 4, job FIFO entries (power of 2, at least 2); TIMEOUT, default 64, watchdog limit in cycles.
REQ-002 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job FIFO can accept.
- in_a, in_b  in  DATA_W  job operands.
- gcd_start  out  1  one-cycle start pulse to the GCD engine.
- gcd_a, gcd_b  out  DATA_W  engine operands.
- gcd_done  in  1  engine completion pulse.
- gcd_result  in  DATA_W  engine result, valid with gcd_done.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_a, out_b, out_gcd  out  DATA_W  echoed operands and their GCD.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- err_timeout  out  1  sticky watchdog flag.

Function
REQ-003 A job SHALL be pushed when in_valid && in_ready; in_ready SHALL equal !full, independent of a pop in the same cycle.
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DELIVER.
REQ-005 IDLE->ISSUE SHALL occur when the FIFO is non-empty and the head has both operands non-zero.
REQ-006 IDLE->DELIVER SHALL occur when the FIFO is non-empty and the head has a zero operand (bypass): out_gcd = in_a|in_b (gcd(0,0)=0), head popped, no gcd_start.
REQ-007 ISSUE SHALL assert gcd_start for exactly one cycle with gcd_a/gcd_b = FIFO head, then go to WAIT.
REQ-008 gcd_a/gcd_b SHALL stay stable from ISSUE until the cycle after gcd_done, and SHALL be 0 otherwise.
REQ-009 In WAIT, gcd_done SHALL capture gcd_result into out_gcd and the head operands into out_a/out_b, pop the FIFO, and go to DELIVER.
REQ-010 gcd_done SHALL be ignored in IDLE, ISSUE and DELIVER.
REQ-011 In DELIVER, out_valid SHALL be 1 and out_* SHALL be held until out_ready; on acceptance the FSM SHALL go to IDLE, so jobs are spaced at least one IDLE cycle apart.
REQ-012 Results SHALL be delivered in push order; at most one job SHALL be outstanding at the engine.
REQ-013 The FIFO pointers SHALL be log2(DEPTH)+1 bits wide with wrap bits; full/empty SHALL be derived from the pointer MSB compare.

Reset
REQ-014 rst_n low SHALL immediately clear: FSM to IDLE, FIFO empty, gcd_start/gcd_a/gcd_b/out_valid/out_a/out_b/out_gcd/busy/err_timeout = 0, in_ready = 1.
REQ-015 A reset during WAIT SHALL discard the in-flight job; a gcd_done arriving after reset release SHALL be ignored (FSM in IDLE).

Configuration
REQ-016 With GCD_ISSUER_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT; when it reaches TIMEOUT without gcd_done, the block SHALL set err_timeout (sticky until reset), pop the head, deliver out_gcd = 0, and go to DELIVER.
REQ-017 Without GCD_ISSUER_TIMEOUT_EN, the counter SHALL be absent, err_timeout SHALL be tied 0, and WAIT SHALL wait indefinitely.

Structure
REQ-018 Package gcd_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, DELIVER), DATA_W_DEFAULT and the job struct {a, b}.
REQ-019 The job FIFO SHALL be a sub-module, gcd_job_fifo (synchronous, DEPTH x 2*DATA_W, show-ahead head).

Verification
REQ-020 The bench SHALL cover these six scenarios with a behavioural GCD engine model (done 5 cycles after start):
- push (56,14) -> exactly one gcd_start, then out_valid with out_gcd = 14.
- push (90,45), (49,57) back-to-back -> outputs 45 then 1 in order, never two starts before the first done.
- push (0,12) and (0,0) -> outputs 12 and 0 with no gcd_start.
- push 5 jobs with out_ready = 0 and the engine stalled -> in_ready = 0 after 4 accepted, 5th not accepted; later drain -> all 4 results correct.
- assert rst_n low during WAIT -> all outputs 0 at once; late gcd_done ignored; next job (32,48) -> 16.
- with GCD_ISSUER_TIMEOUT_EN and the engine never responding -> err_timeout = 1 at TIMEOUT cycles, out_gcd = 0, next job proceeds normally.
